// File: rtl/uncache_wbuf_if.sv
// Bus bundle between the uncached store path, the write buffer and axi_ctrl.
// The slave modport is the buffer's view; master is the surrounding logic's view.
interface uncache_wbuf_if;
  logic        in_wr_req;
  logic [3:0]  in_wstrb;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        in_ready;
  logic        stallreq;
  logic        rd_block;
  logic        unwr_req;
  logic [3:0]  unwr_wstrb;
  logic [31:0] unwr_addr;
  logic [31:0] unwr_data;
  logic        unwr_done;

  modport slave (
    input  in_wr_req, in_wstrb, in_addr, in_data, unwr_done,
    output in_ready, stallreq, rd_block, unwr_req, unwr_wstrb, unwr_addr, unwr_data
  );

  modport master (
    output in_wr_req, in_wstrb, in_addr, in_data, unwr_done,
    input  in_ready, stallreq, rd_block, unwr_req, unwr_wstrb, unwr_addr, unwr_data
  );
endinterface

// File: rtl/uncache_wbuf.sv
// Uncached store write buffer: circular FIFO of stores drained one at a time to
// axi_ctrl, with a one-cycle gap after each write response.
module uncache_wbuf #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic          clk,
  input  logic          resetn,
  uncache_wbuf_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic [67:0]      r_mem [DEPTH];
  logic             r_unwr_req;
  logic [3:0]       r_unwr_wstrb;
  logic [31:0]      r_unwr_addr;
  logic [31:0]      r_unwr_data;

  logic             w_in_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic [1:0]       w_state_nxt;
  logic [PTR_W:0]   w_count_nxt;
  logic [67:0]      w_head_ent;

  assign w_in_ready = (r_count != C_FULL);
  assign w_push     = bus.in_wr_req & w_in_ready;
  assign w_pop      = (r_state == S_ISSUE) & bus.unwr_done;

  // An empty buffer forwards the incoming store straight into the output
  // registers so the request appears the cycle after the push.
  assign w_head_ent = (r_count == '0) ? {bus.in_wstrb, bus.in_addr, bus.in_data}
                                      : r_mem[r_head];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (PTR_W+1)'(1);
      2'b01:   w_count_nxt = r_count - (PTR_W+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) || w_push) begin
          w_state_nxt = S_ISSUE;
          w_load      = 1'b1;
        end
      end
      S_ISSUE: begin
        if (bus.unwr_done) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (r_count != '0) begin
          w_state_nxt = S_ISSUE;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_unwr_req   <= 1'b0;
      r_unwr_wstrb <= '0;
      r_unwr_addr  <= '0;
      r_unwr_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      if (w_load) begin
        r_unwr_req   <= 1'b1;
        r_unwr_wstrb <= w_head_ent[67:64];
        r_unwr_addr  <= w_head_ent[63:32];
        r_unwr_data  <= w_head_ent[31:0];
      end else if (w_pop) begin
        r_unwr_req   <= 1'b0;
      end
    end
  end

  // Entry storage carries no reset; only valid slots are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= {bus.in_wstrb, bus.in_addr, bus.in_data};
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.stallreq   = bus.in_wr_req & ~w_in_ready;
  assign bus.rd_block   = (r_count != '0) || (r_state != S_IDLE);
  assign bus.unwr_req   = r_unwr_req;
  assign bus.unwr_wstrb = r_unwr_wstrb;
  assign bus.unwr_addr  = r_unwr_addr;
  assign bus.unwr_data  = r_unwr_data;

endmodule

// File: tb/tb_uncache_wbuf.sv
// Directed bench for uncache_wbuf: single store, fill/full, full with done,
// ordered drain across pointer wrap, spurious done and reset during issue.
module tb_uncache_wbuf;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  uncache_wbuf_if bus();

  uncache_wbuf #(.DEPTH(4), .PTR_W(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int dly [10] = '{0, 3, 1, 5, 2, 0, 4, 1, 2, 3};
  int pi;
  int di;
  int wait_c;
  logic [31:0] ea;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_wr_req = 1'b0;
    bus.in_wstrb  = 4'h0;
    bus.in_addr   = 32'h0;
    bus.in_data   = 32'h0;
    bus.unwr_done = 1'b0;
  endtask

  task automatic set_push(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    bus.in_wr_req = 1'b1;
    bus.in_wstrb  = s;
    bus.in_addr   = a;
    bus.in_data   = d;
  endtask

  task automatic serve(input logic [31:0] exp_addr);
    int t;
    t = 0;
    while (bus.unwr_req !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    chk("srv_req", 32'(bus.unwr_req), 32'h1);
    chk("srv_addr", bus.unwr_addr, exp_addr);
    bus.unwr_done = 1'b1;
    tick();
    bus.unwr_done = 1'b0;
  endtask

  initial begin
    idle_in();
    resetn = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_stall", 32'(bus.stallreq), 32'h0);
    chk("rst_rdblk", 32'(bus.rd_block), 32'h0);
    chk("rst_req",   32'(bus.unwr_req), 32'h0);
    chk("rst_addr",  bus.unwr_addr, 32'h0);
    resetn = 1'b1;
    tick();

    // single store: push cycle 0, request cycle 1, done cycle 5
    set_push(4'hF, 32'hBFAF_F000, 32'h1234_5678);
    #1;
    chk("s_ready0", 32'(bus.in_ready), 32'h1);
    tick();
    idle_in();
    #1;
    chk("s_req1",   32'(bus.unwr_req), 32'h1);
    chk("s_strb1",  32'(bus.unwr_wstrb), 32'hF);
    chk("s_addr1",  bus.unwr_addr, 32'hBFAF_F000);
    chk("s_data1",  bus.unwr_data, 32'h1234_5678);
    chk("s_rdblk1", 32'(bus.rd_block), 32'h1);
    tick(); tick(); tick();
    chk("s_req4",  32'(bus.unwr_req), 32'h1);
    chk("s_addr4", bus.unwr_addr, 32'hBFAF_F000);
    tick();
    bus.unwr_done = 1'b1;
    tick();
    bus.unwr_done = 1'b0;
    #1;
    chk("s_req6",   32'(bus.unwr_req), 32'h0);
    chk("s_rdblk6", 32'(bus.rd_block), 32'h1);
    tick();
    chk("s_rdblk7", 32'(bus.rd_block), 32'h0);
    chk("s_req7",   32'(bus.unwr_req), 32'h0);

    // spurious done while idle and empty
    bus.unwr_done = 1'b1;
    tick();
    bus.unwr_done = 1'b0;
    #1;
    chk("sp_req",   32'(bus.unwr_req), 32'h0);
    chk("sp_rdblk", 32'(bus.rd_block), 32'h0);
    chk("sp_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("sp_req2",  32'(bus.unwr_req), 32'h0);

    // fill: four accepted, fifth stalls
    for (int i = 0; i < 4; i++) begin
      set_push(4'h3, 32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i));
      #1;
      chk("fill_ready", 32'(bus.in_ready), 32'h1);
      tick();
    end
    set_push(4'h3, 32'hA000_0004, 32'h5000_0004);
    #1;
    chk("full_ready", 32'(bus.in_ready), 32'h0);
    chk("full_stall", 32'(bus.stallreq), 32'h1);
    chk("full_head",  bus.unwr_addr, 32'hA000_0000);
    tick();
    // full with done in the same cycle as the push: still refused
    bus.unwr_done = 1'b1;
    #1;
    chk("fd_ready", 32'(bus.in_ready), 32'h0);
    chk("fd_stall", 32'(bus.stallreq), 32'h1);
    tick();
    bus.unwr_done = 1'b0;
    #1;
    chk("retry_ready", 32'(bus.in_ready), 32'h1);
    chk("retry_stall", 32'(bus.stallreq), 32'h0);
    chk("gap_req",     32'(bus.unwr_req), 32'h0);
    tick();
    idle_in();
    #1;
    chk("refull_ready", 32'(bus.in_ready), 32'h0);
    chk("reissue_req",  32'(bus.unwr_req), 32'h1);
    for (int i = 1; i < 5; i++) serve(32'hA000_0000 + 32'(i));
    tick(); tick();
    chk("drain_rdblk", 32'(bus.rd_block), 32'h0);
    chk("drain_ready", 32'(bus.in_ready), 32'h1);

    // ordered drain across two pointer wraps with varied response delays
    pi = 0; di = 0; wait_c = 0;
    for (int cyc = 0; cyc < 400 && di < 10; cyc++) begin
      bus.unwr_done = 1'b0;
      if (pi < 10) set_push(4'(pi), 32'h1FD0_0000 + 32'(4 * pi), (32'h1FD0_0000 + 32'(4 * pi)) ^ 32'hA5A5_A5A5);
      else begin
        bus.in_wr_req = 1'b0;
      end
      if (bus.unwr_req === 1'b1) begin
        if (wait_c >= dly[di]) begin
          ea = 32'h1FD0_0000 + 32'(4 * di);
          chk("ord_addr", bus.unwr_addr, ea);
          chk("ord_data", bus.unwr_data, ea ^ 32'hA5A5_A5A5);
          chk("ord_strb", 32'(bus.unwr_wstrb), 32'(di[3:0]));
          bus.unwr_done = 1'b1;
          di++;
          wait_c = 0;
        end else begin
          wait_c++;
        end
      end
      #1;
      if (bus.in_wr_req && bus.in_ready) pi++;
      tick();
    end
    idle_in();
    chk("ord_pushed", 32'(pi), 32'd10);
    chk("ord_served", 32'(di), 32'd10);
    tick(); tick();
    chk("ord_rdblk", 32'(bus.rd_block), 32'h0);
    chk("ord_dup",   32'(bus.unwr_req), 32'h0);

    // reset while issuing with three entries, then a stale done
    for (int i = 0; i < 3; i++) begin
      set_push(4'hC, 32'hC000_0000 + 32'(i), 32'h0);
      tick();
    end
    idle_in();
    #1;
    chk("pre_rst_req", 32'(bus.unwr_req), 32'h1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    bus.unwr_done = 1'b1;
    #1;
    chk("mid_rst_req",   32'(bus.unwr_req), 32'h0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'h1);
    chk("mid_rst_rdblk", 32'(bus.rd_block), 32'h0);
    chk("mid_rst_addr",  bus.unwr_addr, 32'h0);
    tick();
    bus.unwr_done = 1'b0;
    #1;
    chk("post_rst_req",   32'(bus.unwr_req), 32'h0);
    chk("post_rst_rdblk", 32'(bus.rd_block), 32'h0);
    set_push(4'h1, 32'hD000_0000, 32'h0000_00EE);
    tick();
    idle_in();
    serve(32'hD000_0000);
    tick(); tick();
    chk("final_rdblk", 32'(bus.rd_block), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uncache_wbuf.md
UNCACHE_WBUF -- requirements
Module: uncache_wbuf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered uncached-store entries (power of two, 2..16).
REQ-002 SHALL have parameter PTR_W, default 2, log2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_wr_req  input  1  uncached store request from the uncached path, qualified by in_ready.
REQ-006 SHALL have port in_wstrb  input  4  byte strobes of the store.
REQ-007 SHALL have port in_addr  input  32  physical byte address of the store.
REQ-008 SHALL have port in_data  input  32  store data.
REQ-009 SHALL have port in_ready  output  1  buffer can accept a store this cycle.
REQ-010 SHALL have port stallreq  output  1  in_wr_req && !in_ready, to the pipeline ctrl.
REQ-011 SHALL have port rd_block  output  1  buffer non-empty; uncached loads SHALL wait while high.
REQ-012 SHALL have port unwr_req  output  1  write request to axi_ctrl, registered.
REQ-013 SHALL have port unwr_wstrb  output  4  strobes of head entry.
REQ-014 SHALL have port unwr_addr  output  32  address of head entry.
REQ-015 SHALL have port unwr_data  output  32  data of head entry.
REQ-016 SHALL have port unwr_done  input  1  one-cycle pulse from axi_ctrl: write response (B) received for current request.

Function
REQ-017 SHALL hold a circular FIFO: head pointer, tail pointer (PTR_W bits, wrap DEPTH-1 -> 0), count (PTR_W+1 bits, 0..DEPTH).
REQ-018 SHALL drive in_ready = (count != DEPTH), combinational from registered count only; no bypass of a pop in the same cycle.
REQ-019 SHALL push on in_wr_req && in_ready: write {wstrb, addr, data} at tail, tail+1, count+1 at next edge.
REQ-020 SHALL accept in_wr_req with in_wstrb == 0 as a normal entry (no filtering).
REQ-021 SHALL implement FSM IDLE / ISSUE / GAP, state registered.
REQ-022 IDLE: unwr_req=0; if count != 0 go ISSUE next cycle.
REQ-023 ISSUE: unwr_req=1, unwr_* equal head entry and SHALL remain stable until unwr_done; on unwr_done pop (head+1, count-1) and go GAP.
REQ-024 GAP: unwr_req=0 for exactly one cycle; next IDLE if count==0 else ISSUE.
REQ-025 SHALL ignore unwr_done in IDLE and GAP (no pop, no count change).
REQ-026 Latency: push at edge N into empty IDLE buffer -> unwr_req high in cycle N+1; unwr_done in cycle M -> unwr_req low in M+1, high again in M+2 if entries remain.
REQ-027 Simultaneous push and pop SHALL give count unchanged, head and tail both advance.
REQ-028 Push while count == DEPTH SHALL be refused (in_ready=0, stallreq=1), even if unwr_done is high that cycle.
REQ-029 SHALL deliver stores to axi_ctrl strictly in push order, exactly once each.
REQ-030 SHALL drive rd_block = (count != 0) || (state != IDLE).

Reset
REQ-031 On resetn=0 at a clock edge SHALL set state=IDLE, head=0, tail=0, count=0, unwr_req=0; unwr_wstrb/addr/data=0; entry storage need not be cleared.
REQ-032 Reset mid-ISSUE SHALL drop all buffered entries and deassert unwr_req next cycle; a pending unwr_done after reset SHALL be ignored.
REQ-033 After reset in_ready=1, stallreq=0, rd_block=0.

Verification
REQ-034 Single store: push {strb=4'hF, addr=32'hBFAF_F000, data=32'h1234_5678} at cycle 0 -> unwr_req=1 cycle 1 with same fields; done at cycle 5 -> unwr_req=0 cycle 6, rd_block=0 cycle 7.
REQ-035 Fill: 5 back-to-back pushes, no done -> first 4 accepted, 5th sees in_ready=0, stallreq=1, count=4.
REQ-036 Full + done same cycle as a push -> push refused, count 3 next cycle; push retried next cycle accepted, count 4.
REQ-037 Order/wrap: 10 pushes with addrs 0x1FD0_0000+4*i interleaved with random-delay done pulses -> axi_ctrl sees addrs i=0..9 in order, pointers wrap twice, no loss or duplicate.
REQ-038 Spurious done in IDLE with count 0 -> no state change, count stays 0; reset asserted in ISSUE with count 3 -> unwr_req=0, count=0, in_ready=1 next cycle.
